fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one floating_point_multiplayer instance among NUM_REQ requesters, such as PE rows of the systolic array.
- Accepts operand pairs over per-requester valid/ready handshakes and issues them to the multiplier one at a time.
- Waits for the multiplier's ready, then routes the result back to the originating requester.
- A watchdog flags a multiplier that never responds.

Parameters:
DATA_WIDTH, 16, operand/result width; must match the multiplier.
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT, 64, max cycles in WAIT before abort (>=2).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  NUM_REQ  per-requester operand valid.
req_ready  output  NUM_REQ  per-requester accept strobe (one-hot or zero).
req_a  input  NUM_REQ*DATA_WIDTH  operand A; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
req_b  input  NUM_REQ*DATA_WIDTH  operand B, same packing.
resp_valid  output  NUM_REQ  one-hot result valid.
resp_ready  input  NUM_REQ  per-requester result accept.
resp_data  output  DATA_WIDTH  result for the requester flagged in resp_valid.
resp_err  output  1  qualifies resp_valid: timeout abort; resp_data=0.
mul_en  output  1  to multiplier en.
mul_a  output  DATA_WIDTH  to multiplier a.
mul_b  output  DATA_WIDTH  to multiplier b.
mul_result  input  DATA_WIDTH  from multiplier result.
mul_ready  input  1  from multiplier ready; result valid when high.
busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rr pointer=0.
  - All outputs 0: req_ready, resp_valid, resp_err, resp_data, mul_en, mul_a, mul_b, busy.
  - Reset mid-operation discards the in-flight op; no response is produced.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after the rr pointer, wrapping modulo NUM_REQ.
  - Same cycle: req_ready[g]=1 (combinational from state and req_valid); A/B are latched from slice g and g is latched; next state is ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE (1 cycle):
  - mul_en=1; mul_a/mul_b drive the latched operands; watchdog counter cleared; next state is WAIT.
- WAIT:
  - mul_en=0; mul_a/mul_b stay held stable.
  - mul_ready=1: capture mul_result, go to RESP with resp_err=0.
  - Counter reaches TIMEOUT-1 with no mul_ready: go to RESP with resp_err=1 and resp_data=0.
  - mul_ready seen in ISSUE or IDLE is ignored (stale).
- RESP:
  - resp_valid[g]=1 and resp_data/resp_err are held until resp_ready[g]=1.
  - On that handshake cycle: rr pointer = (g+1) mod NUM_REQ, next state is IDLE.
  - Other resp_ready bits are ignored.
- Throughput and latency:
  - One op in flight; new requests are not granted outside IDLE.
  - Request acceptance to resp_valid = multiplier latency + 2 cycles.
  - Minimum request-to-request spacing is 4 cycles with a 1-cycle multiplier.
- Fairness:
  - A requester holding req_valid is granted within NUM_REQ ops.
  - A requester may drop req_valid before it is granted; no handshake occurs.
- Invariants:
  - req_ready and resp_valid are each one-hot or zero.
  - No data path exists from requester i to resp_valid[j] for i≠j.

Test Plan:
- Single op, half-precision multiplier: requester 0 sends a=16'h4200 (3.0), b=16'hC600 (-6.0) -> mul_en pulses once; resp_valid=4'b0001, resp_data=16'hCC80, resp_err=0.
- Contention: all four req_valid high from reset, each with a distinct pair -> grants in order 0,1,2,3,0; each resp_valid matches its own product; never two grants overlap.
- Round-robin pointer: requesters 1 and 3 held valid after op on 1 -> next grant is 3, then 1.
- Response backpressure: resp_ready[2] held low 10 cycles -> resp_valid/resp_data stable; no mul_en; no req_ready for other pending requesters until the handshake.
- Timeout: stub never asserts mul_ready, TIMEOUT=8 -> resp_valid after 8 WAIT cycles with resp_err=1, resp_data=0; next request completes normally.
- Async reset in WAIT: reset low mid-cycle -> all outputs 0 immediately; a late mul_ready after release produces no resp_valid; the next request is granted from requester 0.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that time-shares one floating-point multiplier among NUM_REQ requesters,
// with a watchdog that aborts an operation when the multiplier never answers.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | waiting for any req_valid; grants and latches operands on entry
// S_ISSUE | one-cycle mul_en pulse with latched operands, watchdog loaded
// S_WAIT  | operands held, waiting for mul_ready or watchdog terminal count
// S_RESP  | result presented to the granted requester until resp_ready
module fp_mul_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_err,
    output logic                          mul_en,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_b,
    input  logic [DATA_WIDTH-1:0]         mul_result,
    input  logic                          mul_ready,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        gnt_q;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_found;
    logic [DATA_WIDTH-1:0]   op_a, op_b;
    logic [DATA_WIDTH-1:0]   res_q;
    logic                    err_q;
    logic [CNT_W-1:0]        wd_cnt;
    logic                    wd_tc;
    logic                    resp_ack;

    // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [IDX_W:0] sum;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[sum[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = sum[IDX_W-1:0];
            end
        end
    end

    assign wd_tc    = (wd_cnt == '0);
    assign resp_ack = resp_ready[gnt_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (gnt_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (mul_ready || wd_tc) state_nxt = S_RESP;
            S_RESP:  if (resp_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
            gnt_q  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            wd_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        gnt_q <= gnt_idx;
                        op_a  <= req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        op_b  <= req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= CNT_W'(TIMEOUT - 1);
                end
                S_WAIT: begin
                    // A real answer on the terminal-count cycle still wins over the abort.
                    if (mul_ready) begin
                        res_q <= mul_result;
                        err_q <= 1'b0;
                    end else if (wd_tc) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ack) begin
                        rr_ptr <= (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // req_ready is combinational; gating with reset keeps it quiet while reset is held.
    assign req_ready  = (state == S_IDLE && reset && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign resp_valid = (state == S_RESP) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign resp_data  = (state == S_RESP) ? res_q : '0;
    assign resp_err   = (state == S_RESP) ? err_q : 1'b0;
    assign mul_en     = (state == S_ISSUE);
    assign mul_a      = op_a;
    assign mul_b      = op_b;
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: a stub half-precision multiplier with programmable latency,
// a round-robin reference model that predicts grants and responses, and directed plus random phases.
module tb_fp_mul_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a = '0;
    logic [NR*DW-1:0]  req_b = '0;
    logic [NR-1:0]     resp_valid;
    logic [NR-1:0]     resp_ready = '1;
    logic [DW-1:0]     resp_data;
    logic              resp_err;
    logic              mul_en;
    logic [DW-1:0]     mul_a, mul_b;
    logic [DW-1:0]     mul_result;
    logic              mul_ready;
    logic              busy;

    fp_mul_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .mul_en     (mul_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .mul_ready  (mul_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void bound_chk(input string nm, input logic expired);
        nvec++;
        if (expired) begin
            nfail++;
            $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
        end
    endfunction

    // Half-precision multiply through double arithmetic; operands are chosen so products are exact.
    function automatic real h2r(input logic [15:0] x);
        logic [63:0] bits;
        bits = {x[15], 11'(x[14:10]) + 11'd1008, x[9:0], 42'd0};
        return $bitstoreal(bits);
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic [63:0] bits;
        logic [10:0] e;
        bits = $realtobits(r);
        e    = bits[62:52] - 11'd1008;
        return {bits[63], e[4:0], bits[51:42]};
    endfunction

    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        return r2h(h2r(a) * h2r(b));
    endfunction

    function automatic logic [15:0] rnd_op();
        return {1'($urandom), 5'($urandom_range(17, 13)), 3'($urandom), 7'd0};
    endfunction

    // Stub multiplier: answers lat cycles after mul_en; lat==0 means it never answers.
    logic [3:0]  lat = 4'd1;
    logic [3:0]  scnt = '0;
    logic [15:0] sa = 16'h3c00, sb = 16'h3c00;

    always @(posedge clk) begin
        if (mul_en) begin
            scnt <= lat;
            sa   <= mul_a;
            sb   <= mul_b;
        end else if (scnt != 0) begin
            scnt <= scnt - 1'b1;
        end
    end
    assign mul_ready = (scnt == 4'd1);
    always_comb mul_result = fmul(sa, sb);

    // Reference model and scoreboard.
    typedef struct {
        int          g;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    op_t exp_q[$];
    int  glog[$];
    bit  m_busy = 0;
    int  m_ptr = 0;
    int  gcyc = 0;
    int  cyc = 0;
    int  cur_lat = 1;
    int  en_pulses = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("reset_outs", 64'({req_ready, resp_valid, resp_err, resp_data, mul_en, mul_a, mul_b, busy}), 64'd0);
            m_busy = 0;
            m_ptr  = 0;
            exp_q.delete();
        end else if (!m_busy) begin
            int eg;
            chk("busy_idle", 64'(busy), 64'd0);
            chk("resp_valid_idle", 64'(resp_valid), 64'd0);
            chk("mul_en_idle", 64'(mul_en), 64'd0);
            eg = -1;
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (eg < 0 && req_valid[idx]) eg = idx;
            end
            chk("grant", 64'(req_ready), (eg < 0) ? 64'd0 : (64'd1 << eg));
            if (eg >= 0) begin
                op_t o;
                o.g = eg;
                o.a = req_a[eg*DW +: DW];
                o.b = req_b[eg*DW +: DW];
                exp_q.push_back(o);
                glog.push_back(eg);
                m_busy = 1;
                gcyc   = cyc;
            end
        end else begin
            int d, explat;
            d = cyc - gcyc;
            if (mul_en) en_pulses++;
            chk("busy_active", 64'(busy), 64'd1);
            chk("no_grant_busy", 64'(req_ready), 64'd0);
            chk("mul_en_pulse", 64'(mul_en), 64'(d == 1));
            if (d == 1) begin
                chk("mul_a", 64'(mul_a), 64'(exp_q[0].a));
                chk("mul_b", 64'(mul_b), 64'(exp_q[0].b));
                cur_lat = int'(lat);
            end
            explat = (cur_lat == 0) ? TO + 2 : cur_lat + 2;
            if (d < explat) begin
                chk("resp_early", 64'(resp_valid), 64'd0);
            end else begin
                chk("resp_valid", 64'(resp_valid), 64'd1 << exp_q[0].g);
                chk("resp_err", 64'(resp_err), 64'(cur_lat == 0));
                chk("resp_data", 64'(resp_data), (cur_lat == 0) ? 64'd0 : 64'(fmul(exp_q[0].a, exp_q[0].b)));
                if (resp_ready[exp_q[0].g]) begin
                    m_ptr  = (exp_q[0].g + 1) % NR;
                    m_busy = 0;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Stimulus.
    int          auto_mode = 0;
    bit          rand_resp = 0;
    logic [NR-1:0] last_rv = '0;
    logic [DW-1:0] last_rd = '0;
    logic          last_re = 1'b0;

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]       = 1'b1;
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
    endtask

    task automatic step();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        if ((resp_valid & resp_ready) != 0) begin
            last_rv = resp_valid;
            last_rd = resp_data;
            last_re = resp_err;
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
        for (int i = 0; i < NR; i++) begin
            if (auto_mode == 1 && !req_valid[i]) begin
                set_req(i, rnd_op(), rnd_op());
            end else if (auto_mode == 2) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) set_req(i, rnd_op(), rnd_op());
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (rand_resp) begin
            resp_ready = NR'($urandom);
            lat = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
        end
    endtask

    task automatic wait_grant(input int n0, input string nm);
        int t;
        t = 0;
        while (glog.size() <= n0 && t < 200) begin
            step();
            t++;
        end
        bound_chk(nm, glog.size() <= n0);
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while ((req_valid != 0 || m_busy || busy) && t < 400) begin
            step();
            t++;
        end
        bound_chk(nm, req_valid != 0 || m_busy || busy);
    endtask

    initial begin
        int n, en0, t;
        logic [NR-1:0] hold_v;
        logic [DW-1:0] hold_d;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Single op: 3.0 * -6.0 = -18.0
        en0 = en_pulses;
        set_req(0, 16'h4200, 16'hC600);
        wait_idle("single_idle");
        chk("single_valid", 64'(last_rv), 64'h1);
        chk("single_data", 64'(last_rd), 64'hCC80);
        chk("single_err", 64'(last_re), 64'd0);
        chk("single_mul_en_count", 64'(en_pulses - en0), 64'd1);

        // Contention from reset: all four requesting.
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, rnd_op(), rnd_op());
        repeat (2) @(posedge clk);
        glog.delete();
        #1 reset = 1'b1;
        auto_mode = 1;
        t = 0;
        while (glog.size() < 5 && t < 200) begin
            step();
            t++;
        end
        auto_mode = 0;
        bound_chk("contention_grants", glog.size() < 5);
        if (glog.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("contention_order%0d", k), 64'(glog[k]), 64'(k % NR));
        end
        wait_idle("contention_drain");

        // Round robin: after an op on 1, requesters 1 and 3 both valid -> 3 then 1.
        n = glog.size();
        set_req(1, rnd_op(), rnd_op());
        wait_grant(n, "rr_first");
        set_req(1, rnd_op(), rnd_op());
        set_req(3, rnd_op(), rnd_op());
        wait_idle("rr_drain");
        if (glog.size() >= n + 3) begin
            chk("rr_g0", 64'(glog[n]), 64'd1);
            chk("rr_g1", 64'(glog[n+1]), 64'd3);
            chk("rr_g2", 64'(glog[n+2]), 64'd1);
        end else begin
            bound_chk("rr_count", 1'b1);
        end

        // Response backpressure on requester 2.
        n = glog.size();
        set_req(2, rnd_op(), rnd_op());
        wait_grant(n, "bp_grant");
        resp_ready = 4'b1011;
        set_req(0, rnd_op(), rnd_op());
        set_req(1, rnd_op(), rnd_op());
        t = 0;
        while (resp_valid == 0 && t < 50) begin
            step();
            t++;
        end
        bound_chk("bp_resp", resp_valid == 0);
        hold_v = resp_valid;
        hold_d = resp_data;
        en0 = en_pulses;
        repeat (10) step();
        chk("bp_resp_vec", 64'(hold_v), 64'h4);
        chk("bp_valid_hold", 64'(resp_valid), 64'(hold_v));
        chk("bp_data_hold", 64'(resp_data), 64'(hold_d));
        chk("bp_no_mul_en", 64'(en_pulses - en0), 64'd0);
        resp_ready = '1;
        wait_idle("bp_drain");

        // Watchdog abort, then a normal op.
        lat = 4'd0;
        set_req(3, rnd_op(), rnd_op());
        wait_idle("timeout_idle");
        chk("timeout_err", 64'(last_re), 64'd1);
        chk("timeout_data", 64'(last_rd), 64'd0);
        chk("timeout_vec", 64'(last_rv), 64'h8);
        lat = 4'd1;
        set_req(0, 16'h3E00, 16'h4100);
        wait_idle("after_timeout_idle");
        chk("after_timeout_err", 64'(last_re), 64'd0);
        chk("after_timeout_data", 64'(last_rd), 64'(16'h4380));

        // Async reset while waiting on a slow multiplier.
        lat = 4'd6;
        n = glog.size();
        set_req(2, rnd_op(), rnd_op());
        wait_grant(n, "rst_grant");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async_reset_outs", 64'({req_ready, resp_valid, resp_err, resp_data, mul_en, mul_a, mul_b, busy}), 64'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (10) step();
        lat = 4'd1;
        n = glog.size();
        set_req(3, rnd_op(), rnd_op());
        set_req(0, rnd_op(), rnd_op());
        wait_grant(n, "post_reset_grant_wait");
        if (glog.size() > n) chk("post_reset_grant", 64'(glog[n]), 64'd0);
        wait_idle("post_reset_drain");

        // Random traffic.
        auto_mode = 2;
        rand_resp = 1;
        repeat (400) step();
        auto_mode = 0;
        rand_resp = 0;
        resp_ready = '1;
        lat = 4'd1;
        wait_idle("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #400000;
        nvec++;
        nfail++;
        $display("FAIL global_watchdog: simulation did not complete, got running, expected done");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
